// File: rtl/pj_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : pj_bus_arbiter
// Brief    : Two-master round-robin arbiter holding picoJava-II pj_* bus for a
//            whole transaction. Optional ack watchdog: PJ_ARB_ACK_TIMEOUT_EN.
// Revision : 1.0
// ============================================================================
module pj_bus_arbiter #(
    parameter int ADDR_W  = 30,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 63
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              pj_standby_out,
    input  logic              m0_tv,
    input  logic              m1_tv,
    input  logic [3:0]        m0_type,
    input  logic [3:0]        m1_type,
    input  logic [1:0]        m0_size,
    input  logic [1:0]        m1_size,
    input  logic [ADDR_W-1:0] m0_address,
    input  logic [ADDR_W-1:0] m1_address,
    input  logic [DATA_W-1:0] m0_data_out,
    input  logic [DATA_W-1:0] m1_data_out,
    output logic [1:0]        m0_ack,
    output logic [1:0]        m1_ack,
    output logic [DATA_W-1:0] m0_data_in,
    output logic [DATA_W-1:0] m1_data_in,
    output logic              pj_tv,
    output logic [3:0]        pj_type,
    output logic [1:0]        pj_size,
    output logic [ADDR_W-1:0] pj_address,
    output logic [DATA_W-1:0] pj_data_out,
    input  logic [1:0]        pj_ack,
    input  logic [DATA_W-1:0] pj_data_in,
    output logic [1:0]        grant
);

    // State encoding doubles as the one-hot grant vector.
    localparam logic [1:0] C_ST_IDLE = 2'b00;
    localparam logic [1:0] C_ST_OWN0 = 2'b01;
    localparam logic [1:0] C_ST_OWN1 = 2'b10;

    logic [1:0]        state_q, state_d;
    logic              last_owner_q, last_owner_d;
    logic [2:0]        ack_cnt_q, ack_cnt_d;
    logic              illegal_q, illegal_d;

    logic              w_owning;
    logic              w_owner;
    logic              w_own_tv;
    logic [3:0]        w_own_type;
    logic [1:0]        w_own_size;
    logic [ADDR_W-1:0] w_own_addr;
    logic [DATA_W-1:0] w_own_wdata;
    logic [1:0]        w_own_ack;
    logic [DATA_W-1:0] w_own_rdata;
    logic              w_arb_go;
    logic              w_winner;
    logic [2:0]        w_win_acks;
    logic              w_done;
    logic              w_timeout;

    // Number of acks that make up a transaction; zero marks an illegal type.
    function automatic logic [2:0] acks_for_type(input logic [2:0] t);
        case (t)
            3'b000:                 return 3'd2;
            3'b010, 3'b110, 3'b111: return 3'd1;
            3'b100, 3'b101:         return 3'd4;
            default:                return 3'd0;
        endcase
    endfunction

    assign w_owning    = (state_q != C_ST_IDLE);
    assign w_owner     = (state_q == C_ST_OWN1);
    assign w_own_tv    = w_owner ? m1_tv       : m0_tv;
    assign w_own_type  = w_owner ? m1_type     : m0_type;
    assign w_own_size  = w_owner ? m1_size     : m0_size;
    assign w_own_addr  = w_owner ? m1_address  : m0_address;
    assign w_own_wdata = w_owner ? m1_data_out : m0_data_out;

    assign w_arb_go   = !pj_standby_out && (m0_tv || m1_tv);
    assign w_winner   = (m0_tv && m1_tv) ? !last_owner_q : m1_tv;
    assign w_win_acks = acks_for_type(w_winner ? m1_type[2:0] : m0_type[2:0]);

`ifdef PJ_ARB_ACK_TIMEOUT_EN
    logic [5:0] wdog_q, wdog_d;

    // Idle cycles keep the watchdog at zero, so every grant starts it fresh.
    always_comb begin
        wdog_d = 6'd0;
        if (w_owning && pj_ack == 2'b00) begin
            wdog_d = wdog_q + 6'd1;
        end
    end

    assign w_timeout = w_owning && !illegal_q && w_own_tv && (pj_ack == 2'b00) &&
                       (wdog_q == 6'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            wdog_q <= 6'd0;
        end else begin
            wdog_q <= wdog_d;
        end
    end
`else
    logic [31:0] w_unused_timeout;
    assign w_unused_timeout = 32'(TIMEOUT);
    assign w_timeout        = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        last_owner_d = last_owner_q;
        ack_cnt_d    = ack_cnt_q;
        illegal_d    = illegal_q;
        w_done       = 1'b0;
        case (state_q)
            C_ST_IDLE: begin
                if (w_arb_go) begin
                    state_d   = w_winner ? C_ST_OWN1 : C_ST_OWN0;
                    ack_cnt_d = w_win_acks;
                    illegal_d = (w_win_acks == 3'd0);
                end
            end
            default: begin
                // Dropped valid, error ack, illegal type and watchdog all end the grant.
                if (illegal_q || !w_own_tv || w_timeout || pj_ack[1]) begin
                    w_done = 1'b1;
                end else if (pj_ack == 2'b01) begin
                    ack_cnt_d = ack_cnt_q - 3'd1;
                    if (ack_cnt_q == 3'd1) begin
                        w_done = 1'b1;
                    end
                end
                if (w_done) begin
                    state_d      = C_ST_IDLE;
                    last_owner_d = w_owner;
                    illegal_d    = 1'b0;
                end
            end
        endcase
    end

    always_comb begin
        pj_tv       = 1'b0;
        pj_type     = 4'h0;
        pj_size     = 2'b00;
        pj_address  = '0;
        pj_data_out = '0;
        w_own_ack   = 2'b00;
        w_own_rdata = '0;
        if (w_owning) begin
            if (illegal_q) begin
                w_own_ack = 2'b10;
            end else begin
                pj_tv       = w_own_tv && !w_timeout;
                pj_type     = w_own_type;
                pj_size     = w_own_size;
                pj_address  = w_own_addr;
                pj_data_out = w_own_wdata;
                if (w_timeout) begin
                    w_own_ack = 2'b10;
                end else if (w_own_tv) begin
                    w_own_ack   = pj_ack;
                    w_own_rdata = pj_data_in;
                end
            end
        end
        m0_ack     = (state_q == C_ST_OWN0) ? w_own_ack   : 2'b00;
        m1_ack     = (state_q == C_ST_OWN1) ? w_own_ack   : 2'b00;
        m0_data_in = (state_q == C_ST_OWN0) ? w_own_rdata : '0;
        m1_data_in = (state_q == C_ST_OWN1) ? w_own_rdata : '0;
    end

    assign grant = state_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= C_ST_IDLE;
            last_owner_q <= 1'b1;
            ack_cnt_q    <= 3'd0;
            illegal_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_owner_q <= last_owner_d;
            ack_cnt_q    <= ack_cnt_d;
            illegal_q    <= illegal_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pj_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_pj_bus_arbiter
// Brief    : Scoreboard bench for pj_bus_arbiter; directed transactions.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_pj_bus_arbiter;

    localparam int ADDR_W  = 30;
    localparam int DATA_W  = 32;
    localparam int TIMEOUT = 63;

    logic              clk = 1'b0;
    logic              reset;
    logic              pj_standby_out;
    logic              m0_tv, m1_tv;
    logic [3:0]        m0_type, m1_type;
    logic [1:0]        m0_size, m1_size;
    logic [ADDR_W-1:0] m0_address, m1_address;
    logic [DATA_W-1:0] m0_data_out, m1_data_out;
    logic [1:0]        m0_ack, m1_ack;
    logic [DATA_W-1:0] m0_data_in, m1_data_in;
    logic              pj_tv;
    logic [3:0]        pj_type;
    logic [1:0]        pj_size;
    logic [ADDR_W-1:0] pj_address;
    logic [DATA_W-1:0] pj_data_out;
    logic [1:0]        pj_ack;
    logic [DATA_W-1:0] pj_data_in;
    logic [1:0]        grant;

    always #5 clk = ~clk;

    pj_bus_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset), .pj_standby_out(pj_standby_out),
        .m0_tv(m0_tv), .m1_tv(m1_tv), .m0_type(m0_type), .m1_type(m1_type),
        .m0_size(m0_size), .m1_size(m1_size),
        .m0_address(m0_address), .m1_address(m1_address),
        .m0_data_out(m0_data_out), .m1_data_out(m1_data_out),
        .m0_ack(m0_ack), .m1_ack(m1_ack),
        .m0_data_in(m0_data_in), .m1_data_in(m1_data_in),
        .pj_tv(pj_tv), .pj_type(pj_type), .pj_size(pj_size),
        .pj_address(pj_address), .pj_data_out(pj_data_out),
        .pj_ack(pj_ack), .pj_data_in(pj_data_in), .grant(grant)
    );

    typedef struct {
        int                cyc;
        string             nm;
        logic [1:0]        g;
        logic              tv;
        logic [3:0]        ty;
        logic [ADDR_W-1:0] ad;
        logic [1:0]        a0;
        logic [1:0]        a1;
        logic [DATA_W-1:0] d0;
        logic [DATA_W-1:0] d1;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   cyc      = 0;
    int   n_checks = 0;
    int   n_pass   = 0;
    bit   mon_en   = 1'b0;
    bit   done     = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: any owned cycle is a DUT output event; idle probes are due by cycle.
    always @(negedge clk) begin
        if (mon_en) begin
            if (sb.size() > 0 && sb[0].cyc <= cyc) begin
                e = sb.pop_front();
                n_checks++;
                if (e.cyc == cyc && grant == e.g && pj_tv == e.tv && pj_type == e.ty &&
                    pj_address == e.ad && m0_ack == e.a0 && m1_ack == e.a1 &&
                    m0_data_in == e.d0 && m1_data_in == e.d1) begin
                    n_pass++;
                end else begin
                    $display("FAIL %s cyc=%0d got g=%b tv=%b ty=%h ad=%h a0=%b a1=%b d0=%h d1=%h, required cyc=%0d g=%b tv=%b ty=%h ad=%h a0=%b a1=%b d0=%h d1=%h",
                             e.nm, cyc, grant, pj_tv, pj_type, pj_address, m0_ack, m1_ack,
                             m0_data_in, m1_data_in, e.cyc, e.g, e.tv, e.ty, e.ad, e.a0,
                             e.a1, e.d0, e.d1);
                end
            end else if (grant != 2'b00) begin
                n_checks++;
                $display("FAIL unexpected_owned_cycle cyc=%0d got grant=%b pj_tv=%b m0_ack=%b m1_ack=%b, required no owned cycle",
                         cyc, grant, pj_tv, m0_ack, m1_ack);
            end
            if (done) begin
                n_checks++;
                if (sb.size() == 0) n_pass++;
                else $display("FAIL scoreboard_drain got %0d pending, required 0", sb.size());
                $display("%0d/%0d checks passed", n_pass, n_checks);
                $finish;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input string nm, input logic [1:0] g, input logic tv,
                        input logic [3:0] ty, input logic [ADDR_W-1:0] ad,
                        input logic [1:0] a0, input logic [1:0] a1,
                        input logic [DATA_W-1:0] d0, input logic [DATA_W-1:0] d1);
        exp_t x;
        x.cyc = cyc; x.nm = nm; x.g = g; x.tv = tv; x.ty = ty; x.ad = ad;
        x.a0 = a0; x.a1 = a1; x.d0 = d0; x.d1 = d1;
        sb.push_back(x);
    endtask

    // One owned cycle: drive memory response, queue what the owner must see.
    task automatic beat(input string nm, input logic [1:0] ack, input bit fwd,
                        input logic [1:0] g, input logic tv, input logic [3:0] ty,
                        input logic [ADDR_W-1:0] ad, input logic [1:0] a0,
                        input logic [1:0] a1);
        logic [DATA_W-1:0] dat;
        dat        = 32'hD000_0000 + 32'(cyc);
        pj_ack     = ack;
        pj_data_in = dat;
        push(nm, g, tv, ty, ad, a0, a1, (fwd && g == 2'b01) ? dat : '0,
             (fwd && g == 2'b10) ? dat : '0);
        tick();
    endtask

    task automatic idle_cycle(input string nm);
        pj_ack = 2'b00;
        push(nm, 2'b00, 1'b0, 4'h0, '0, 2'b00, 2'b00, '0, '0);
        tick();
    endtask

    task automatic req(input int m, input logic [3:0] ty, input logic [ADDR_W-1:0] ad);
        if (m == 0) begin
            m0_tv = 1'b1; m0_type = ty; m0_size = 2'b10; m0_address = ad;
            m0_data_out = 32'hCAFE_0000 | 32'(ad);
        end else begin
            m1_tv = 1'b1; m1_type = ty; m1_size = 2'b10; m1_address = ad;
            m1_data_out = 32'hBEEF_0000 | 32'(ad);
        end
    endtask

    initial begin
        reset = 1'b1; pj_standby_out = 1'b0;
        m0_tv = 1'b0; m0_type = 4'h0; m0_size = 2'b00; m0_address = '0; m0_data_out = '0;
        m1_tv = 1'b0; m1_type = 4'h0; m1_size = 2'b00; m1_address = '0; m1_data_out = '0;
        pj_ack = 2'b00; pj_data_in = '0;
        tick(); tick();
        mon_en = 1'b1;
        idle_cycle("reset_state");
        reset = 1'b0;

        // Four-ack read burst from m0
        req(0, 4'b0100, 30'h100);
        tick();
        for (int k = 0; k < 4; k++)
            beat($sformatf("burst4_b%0d", k), 2'b01, 1'b1, 2'b01, 1'b1, 4'b0100, 30'h100, 2'b01, 2'b00);
        m0_tv = 1'b0;
        idle_cycle("burst4_done");

        // Tie from reset: m0 first, then m1 wins the next tie
        reset = 1'b1;
        tick();
        reset = 1'b0;
        req(0, 4'b0010, 30'h200);
        req(1, 4'b0010, 30'h300);
        tick();
        beat("rr_m0", 2'b01, 1'b1, 2'b01, 1'b1, 4'b0010, 30'h200, 2'b01, 2'b00);
        req(0, 4'b0110, 30'h204);
        idle_cycle("rr_gap");
        beat("rr_m1", 2'b01, 1'b1, 2'b10, 1'b1, 4'b0010, 30'h300, 2'b00, 2'b01);
        m1_tv = 1'b0;
        idle_cycle("rr_gap2");
        beat("m0_ioerr", 2'b11, 1'b1, 2'b01, 1'b1, 4'b0110, 30'h204, 2'b11, 2'b00);
        m0_tv = 1'b0;
        idle_cycle("ioerr_done");

        // Memory error terminates a two-ack transaction early
        req(1, 4'b0000, 30'h40);
        tick();
        beat("m1_ack1", 2'b01, 1'b1, 2'b10, 1'b1, 4'b0000, 30'h40, 2'b00, 2'b01);
        beat("m1_memerr", 2'b10, 1'b1, 2'b10, 1'b1, 4'b0000, 30'h40, 2'b00, 2'b10);
        m1_tv = 1'b0;
        req(0, 4'b0010, 30'h44);
        idle_cycle("memerr_done");
        beat("after_err", 2'b01, 1'b1, 2'b01, 1'b1, 4'b0010, 30'h44, 2'b01, 2'b00);
        m0_tv = 1'b0;

        // Illegal type: not forwarded, one error ack, memory ack ignored
        req(0, 4'b0001, 30'h50);
        tick();
        beat("illegal", 2'b01, 1'b0, 2'b01, 1'b0, 4'h0, '0, 2'b10, 2'b00);
        m0_tv = 1'b0;
        idle_cycle("illegal_done");

        // Standby blocks new grants but not one already in flight
        pj_standby_out = 1'b1;
        req(0, 4'b0000, 30'h60);
        for (int k = 0; k < 10; k++) idle_cycle($sformatf("standby_%0d", k));
        pj_standby_out = 1'b0;
        tick();
        beat("sb_b0", 2'b01, 1'b1, 2'b01, 1'b1, 4'b0000, 30'h60, 2'b01, 2'b00);
        pj_standby_out = 1'b1;
        beat("sb_b1", 2'b01, 1'b1, 2'b01, 1'b1, 4'b0000, 30'h60, 2'b01, 2'b00);
        m0_tv = 1'b0;
        pj_standby_out = 1'b0;
        idle_cycle("sb_done");

        // Owner drops valid mid-transaction: abort, late ack not returned
        req(1, 4'b0100, 30'h70);
        tick();
        beat("abort_b0", 2'b01, 1'b1, 2'b10, 1'b1, 4'b0100, 30'h70, 2'b00, 2'b01);
        m1_tv = 1'b0;
        beat("abort_late", 2'b01, 1'b0, 2'b10, 1'b0, 4'b0100, 30'h70, 2'b00, 2'b00);
        req(0, 4'b0010, 30'h74);
        idle_cycle("abort_idle");
        beat("post_abort", 2'b01, 1'b1, 2'b01, 1'b1, 4'b0010, 30'h74, 2'b01, 2'b00);
        m0_tv = 1'b0;

        // Reset after two of four acks
        req(0, 4'b0101, 30'h80);
        tick();
        beat("rst_b0", 2'b01, 1'b1, 2'b01, 1'b1, 4'b0101, 30'h80, 2'b01, 2'b00);
        beat("rst_b1", 2'b01, 1'b1, 2'b01, 1'b1, 4'b0101, 30'h80, 2'b01, 2'b00);
        reset = 1'b1;
        beat("rst_inflight", 2'b00, 1'b1, 2'b01, 1'b1, 4'b0101, 30'h80, 2'b00, 2'b00);
        m0_tv = 1'b0;
        idle_cycle("rst_cleared");
        reset = 1'b0;
        req(0, 4'b0010, 30'h84);
        tick();
        beat("post_rst", 2'b01, 1'b1, 2'b01, 1'b1, 4'b0010, 30'h84, 2'b01, 2'b00);
        m0_tv = 1'b0;
        idle_cycle("post_rst_idle");

`ifdef PJ_ARB_ACK_TIMEOUT_EN
        // Memory never answers: error on the TIMEOUT-th owned cycle
        req(0, 4'b0010, 30'h90);
        tick();
        for (int k = 1; k < TIMEOUT; k++)
            beat($sformatf("wd_wait_%0d", k), 2'b00, 1'b1, 2'b01, 1'b1, 4'b0010, 30'h90, 2'b00, 2'b00);
        beat("wd_fire", 2'b00, 1'b0, 2'b01, 1'b0, 4'b0010, 30'h90, 2'b10, 2'b00);
        m0_tv = 1'b0;
        idle_cycle("wd_done");
`endif

        tick();
        done = 1'b1;
        repeat (4) @(posedge clk);
        $display("FAIL monitor_stalled got no summary, required summary line");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/pj_bus_arbiter.md
Name: pj_bus_arbiter

Overview:
- Two-master arbiter for the picoJava-II memory bus.
- Shares one pj_* transaction port to memory between master 0 (core) and master 1 (DMA/test engine).
- Holds the grant for a whole transaction by counting acks per transaction type, so the downstream memory and bus monitor see legal, non-interleaved transactions.
- Round-robin fairness; blocks new grants while the core is in standby.

Parameters:
- ADDR_W, 30, word address width
- DATA_W, 32, data bus width
- TIMEOUT, 63, max cycles with no ack before forced termination (used only with the optional feature)

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- pj_standby_out  in  1  core in standby; no new grants while high
- m0_tv, m1_tv  in  1 each  master transaction valid
- m0_type, m1_type  in  4 each  transaction type (pj_type encoding)
- m0_size, m1_size  in  2 each  transaction size
- m0_address, m1_address  in  ADDR_W each  word address
- m0_data_out, m1_data_out  in  DATA_W each  store data
- m0_ack, m1_ack  out  2 each  ack returned to master
- m0_data_in, m1_data_in  out  DATA_W each  load data to master
- pj_tv  out  1  bus transaction valid
- pj_type  out  4  bus type
- pj_size  out  2  bus size
- pj_address  out  ADDR_W  bus address
- pj_data_out  out  DATA_W  bus store data
- pj_ack  in  2  memory ack: 00 none, 01 ack, 10 mem error, 11 io error
- pj_data_in  in  DATA_W  memory load data
- grant  out  2  one-hot current owner (debug)

Behaviour:
- States: IDLE, OWN0, OWN1.
- Reset values:
  - state=IDLE, grant=00, pj_tv=0.
  - pj_type/pj_size/pj_address/pj_data_out=0.
  - m*_ack=00, m*_data_in=0, ack counter=0.
  - last_owner=1, so master 0 wins the first tie.
- IDLE:
  - Arbitrate when pj_standby_out=0 and at least one mX_tv=1.
  - Single requester wins.
  - Both requesting: winner is the master that is not last_owner.
  - On grant: go to OWNx next cycle; load ack counter from the winner's type[2:0]:
    - 000 -> 2; 010 -> 1; 100 -> 4; 101 -> 4; 110 -> 1; 111 -> 1.
- Grant latency: request sampled in IDLE at edge N; pj_tv=1 in cycle N+1.
- OWNx:
  - pj_tv/type/size/address/data_out are the owner's inputs, passed through combinationally.
  - Non-owned bus outputs are 0 when IDLE.
  - pj_ack and pj_data_in go to the owner's m*_ack/m*_data_in combinationally; the non-owner sees ack 00 and data 0.
- Completion:
  - pj_ack=01 decrements the counter. The ack that drives it from 1 to 0 is the final ack; return to IDLE at the next edge and set last_owner=x.
  - pj_ack=10 or 11 is an error ack: final regardless of count, return to IDLE, set last_owner=x.
- Minimum one IDLE cycle (pj_tv=0) between transactions, so each new transaction is seen with pj_tv low first.
- Owner drops mX_tv before the final ack: abort to IDLE next edge; late acks are ignored.
- Illegal type 001/011 at grant:
  - Not forwarded; pj_tv stays 0.
  - State goes to OWNx for exactly one cycle, returning m*_ack=10 to that master; then IDLE.
- Grants are not taken while OWNx, whatever pj_standby_out does; an in-flight transaction always completes.
- Reset mid-transaction: everything returns to reset values at that edge; the ack counter is cleared.

Optional Feature:
- Macro: PJ_ARB_ACK_TIMEOUT_EN.
- Enabled:
  - A 6-bit watchdog clears on grant and on any nonzero pj_ack, and counts every OWNx cycle otherwise.
  - At TIMEOUT: drive m*_ack=10 to the owner for that cycle, drop pj_tv, return to IDLE, update last_owner.
- Disabled: no watchdog; the arbiter waits indefinitely for acks.

Test Plan:
- m0 type 0100, address 30'h100, memory acks 01 on 4 consecutive cycles -> pj_tv high exactly 4 cycles, m0_ack=01 x4, then pj_tv low, grant=00.
- m0 and m1 both request type 0010 from reset -> m0 granted first (grant=01); after 1 ack, one idle cycle, then m1 granted (grant=10).
- m1 type 0000, memory returns 01 then 10 -> m1 sees 01 then 10; transaction ends after the error; next request is accepted.
- m0 type 0001 -> pj_tv never asserted; m0_ack=10 for one cycle, 2 cycles after request.
- pj_standby_out=1 with m0_tv=1 for 10 cycles -> no grant, pj_tv=0; standby falls -> pj_tv=1 next cycle+1.
- PJ_ARB_ACK_TIMEOUT_EN, TIMEOUT=63, memory never acks -> m0_ack=10 on cycle 63 of OWN0, then IDLE. Also assert reset mid-burst after 2 of 4 acks -> all outputs 0 at next edge.
